// File: rtl/ex_stage_if.sv
// EX stage bundle: ID/EX control and datapath, forwarding inputs,
// registered EX/MEM results, the stall request and debug taps for the
// multiply/divide unit.
//
// Handshake: an instruction presented to EX is consumed at a rising edge
// when md_stall is low; while md_stall is high the producer (ID/EX and
// earlier) holds it, and EX/MEM receives a bubble for that edge.
interface ex_stage_if;
  logic        RegWrite_in, MemtoReg_in, Branch_in, MemRead_in;
  logic        MemWrite_in, Jump_in, RegDst_in, ALUSrc_in;
  logic [1:0]  ALUOp_in;
  logic [31:0] jump_addr_in, PC_plus4_in;
  logic [31:0] reg_read_data_1_in, reg_read_data_2_in, immi_sign_extended_in;
  logic [4:0]  Rs_in, Rt_in, Rd_in;
  logic [5:0]  funct_in;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] ex_mem_fwd, mem_wb_fwd;

  logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
  logic        Jump_out, branch_taken_out;
  logic [31:0] alu_result_out, store_data_out, branch_target_out, jump_addr_out;
  logic [4:0]  write_reg_out;
  logic        md_stall;

  logic        md_busy_dbg;
  logic [5:0]  md_cnt_dbg;
  logic [31:0] hi_dbg, lo_dbg;

  modport master (
    output RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in,
           Jump_in, RegDst_in, ALUSrc_in, ALUOp_in, jump_addr_in, PC_plus4_in,
           reg_read_data_1_in, reg_read_data_2_in, immi_sign_extended_in,
           Rs_in, Rt_in, Rd_in, funct_in, ForwardA, ForwardB,
           ex_mem_fwd, mem_wb_fwd,
    input  RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Jump_out,
           branch_taken_out, alu_result_out, store_data_out, branch_target_out,
           jump_addr_out, write_reg_out, md_stall,
           md_busy_dbg, md_cnt_dbg, hi_dbg, lo_dbg
  );

  modport slave (
    input  RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in,
           Jump_in, RegDst_in, ALUSrc_in, ALUOp_in, jump_addr_in, PC_plus4_in,
           reg_read_data_1_in, reg_read_data_2_in, immi_sign_extended_in,
           Rs_in, Rt_in, Rd_in, funct_in, ForwardA, ForwardB,
           ex_mem_fwd, mem_wb_fwd,
    output RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Jump_out,
           branch_taken_out, alu_result_out, store_data_out, branch_target_out,
           jump_addr_out, write_reg_out, md_stall,
           md_busy_dbg, md_cnt_dbg, hi_dbg, lo_dbg
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, branch resolution, EX/MEM output
// register and an iterative 32-step multiply/divide unit with HI/LO.
module ex_stage (
  input logic     clk,
  input logic     rst,
  ex_stage_if.slave bus
);

  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

  md_state_t   state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;       // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] opb_q;       // multiplicand / divisor magnitude
  logic        md_div_q, neg_q_q, neg_r_q, div_zero_q;
  logic [31:0] hi_q, lo_q;

  logic [31:0] op_a, fwd_b, op_b, alu_res;
  logic        is_md, is_mf, md_signed, md_issue, md_done, stall;

  // Operand selection from register file or forwarding paths.
  always_comb begin
    op_a = bus.reg_read_data_1_in;
    case (bus.ForwardA)
      2'b10:   op_a = bus.ex_mem_fwd;
      2'b01:   op_a = bus.mem_wb_fwd;
      default: op_a = bus.reg_read_data_1_in;
    endcase
    fwd_b = bus.reg_read_data_2_in;
    case (bus.ForwardB)
      2'b10:   fwd_b = bus.ex_mem_fwd;
      2'b01:   fwd_b = bus.mem_wb_fwd;
      default: fwd_b = bus.reg_read_data_2_in;
    endcase
    op_b = bus.ALUSrc_in ? bus.immi_sign_extended_in : fwd_b;
  end

  // Instruction class decode and stall request.
  always_comb begin
    is_md = (bus.ALUOp_in == 2'b10) &&
            ((bus.funct_in == 6'h18) || (bus.funct_in == 6'h19) ||
             (bus.funct_in == 6'h1A) || (bus.funct_in == 6'h1B));
    is_mf = (bus.ALUOp_in == 2'b10) &&
            ((bus.funct_in == 6'h10) || (bus.funct_in == 6'h12));
    md_signed = ~bus.funct_in[0];
    stall    = (state_q == MD_BUSY) && (is_md || is_mf);
    md_issue = (state_q == MD_IDLE) && is_md;
    md_done  = (state_q == MD_BUSY) && ((cnt_q == 6'd1) || div_zero_q);
  end

  // ALU result; multiply/divide functs produce 0 here, their result lands in HI/LO.
  always_comb begin
    alu_res = 32'd0;
    case (bus.ALUOp_in)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b11: alu_res = op_a | op_b;
      default: begin
        case (bus.funct_in)
          6'h20, 6'h21: alu_res = op_a + op_b;
          6'h22, 6'h23: alu_res = op_a - op_b;
          6'h24:        alu_res = op_a & op_b;
          6'h25:        alu_res = op_a | op_b;
          6'h27:        alu_res = ~(op_a | op_b);
          6'h2A:        alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
          6'h2B:        alu_res = {31'd0, op_a < op_b};
          6'h10:        alu_res = hi_q;
          6'h12:        alu_res = lo_q;
          default:      alu_res = 32'd0;
        endcase
      end
    endcase
  end

  // One shift-add and one restoring-subtract step, plus sign-corrected final values.
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [63:0] mul_next, div_next, prod_fix;
  logic [31:0] quo_fix, rem_fix, zero_hi;
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_trial = div_shift - {1'b0, opb_q};
    div_next  = div_trial[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                              : {div_trial[31:0], acc_q[30:0], 1'b1};
    prod_fix  = neg_q_q ? -mul_next : mul_next;
    quo_fix   = neg_q_q ? -div_next[31:0] : div_next[31:0];
    rem_fix   = neg_r_q ? -div_next[63:32] : div_next[63:32];
    zero_hi   = neg_r_q ? -acc_q[31:0] : acc_q[31:0];
  end

  // Multiply/divide FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  // Multiply/divide FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (md_issue) state_d = MD_BUSY;
      MD_BUSY: if (md_done)  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Multiply/divide datapath: capture magnitudes on issue, iterate while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 6'd0; acc_q <= 64'd0; opb_q <= 32'd0;
      md_div_q <= 1'b0; neg_q_q <= 1'b0; neg_r_q <= 1'b0; div_zero_q <= 1'b0;
      hi_q <= 32'd0; lo_q <= 32'd0;
    end else if (md_issue) begin
      cnt_q      <= 6'd32;
      acc_q      <= {32'd0, (md_signed && op_a[31]) ? -op_a : op_a};
      opb_q      <= (md_signed && op_b[31]) ? -op_b : op_b;
      md_div_q   <= bus.funct_in[1];
      neg_q_q    <= md_signed & (op_a[31] ^ op_b[31]);
      neg_r_q    <= md_signed & op_a[31];
      div_zero_q <= bus.funct_in[1] && (op_b == 32'd0);
    end else if (state_q == MD_BUSY) begin
      cnt_q <= md_done ? 6'd0 : cnt_q - 6'd1;
      acc_q <= md_div_q ? div_next : mul_next;
      if (md_done) begin
        if (div_zero_q) begin
          hi_q <= zero_hi;
          lo_q <= 32'hFFFF_FFFF;
        end else if (md_div_q) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          hi_q <= prod_fix[63:32];
          lo_q <= prod_fix[31:0];
        end
      end
    end
  end

  // EX/MEM output register: bubble on reset or stall, otherwise load results.
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      bus.RegWrite_out <= 1'b0; bus.MemtoReg_out <= 1'b0;
      bus.MemRead_out <= 1'b0;  bus.MemWrite_out <= 1'b0;
      bus.Jump_out <= 1'b0;     bus.branch_taken_out <= 1'b0;
      bus.alu_result_out <= 32'd0;    bus.store_data_out <= 32'd0;
      bus.branch_target_out <= 32'd0; bus.jump_addr_out <= 32'd0;
      bus.write_reg_out <= 5'd0;
    end else begin
      bus.RegWrite_out     <= bus.RegWrite_in & ~is_md;
      bus.MemtoReg_out     <= bus.MemtoReg_in;
      bus.MemRead_out      <= bus.MemRead_in;
      bus.MemWrite_out     <= bus.MemWrite_in;
      bus.Jump_out         <= bus.Jump_in;
      bus.branch_taken_out <= bus.Branch_in && ((op_a - op_b) == 32'd0);
      bus.alu_result_out   <= alu_res;
      bus.store_data_out   <= fwd_b;
      bus.branch_target_out <= bus.PC_plus4_in + {bus.immi_sign_extended_in[29:0], 2'b00};
      bus.jump_addr_out    <= bus.jump_addr_in;
      bus.write_reg_out    <= bus.RegDst_in ? bus.Rd_in : bus.Rt_in;
    end
  end

  assign bus.md_stall    = stall;
  assign bus.md_busy_dbg = (state_q == MD_BUSY);
  assign bus.md_cnt_dbg  = cnt_q;
  assign bus.hi_dbg      = hi_q;
  assign bus.lo_dbg      = lo_q;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in, RegDst_in, ALUSrc_in  in  1 each  control from the ID/EX register.
REQ-004 ALUOp_in  in  2  ALU class: 00 add, 01 sub, 10 R-type by funct, 11 or.
REQ-005 jump_addr_in, PC_plus4_in, reg_read_data_1_in, reg_read_data_2_in, immi_sign_extended_in  in  32 each  datapath from ID/EX.
REQ-006 Rs_in, Rt_in, Rd_in  in  5 each; funct_in  in  6.
REQ-007 ForwardA, ForwardB  in  2 each  operand select: 00 register file, 10 ex_mem_fwd, 01 mem_wb_fwd, 11 register file.
REQ-008 ex_mem_fwd, mem_wb_fwd  in  32 each  forwarded results.
REQ-009 RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Jump_out, branch_taken_out  out  1 each  registered EX/MEM control.
REQ-010 alu_result_out, store_data_out, branch_target_out, jump_addr_out  out  32 each; write_reg_out  out  5.
REQ-011 md_stall  out  1  combinational; high = ID/EX and earlier stages must hold.

Function
REQ-012 Operand A = ForwardA-selected value; operand B = immi_sign_extended_in if ALUSrc_in, else ForwardB-selected value; store_data = ForwardB-selected value.
REQ-013 R-type funct: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed), 0x2B sltu, 0x10 mfhi, 0x12 mflo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu; any other funct gives result 0.
REQ-014 Arithmetic: 32-bit, wrap-around, no overflow trap.
REQ-015 write_reg = Rd_in if RegDst_in, else Rt_in.
REQ-016 branch_target = PC_plus4_in + (immi_sign_extended_in << 2), truncated to 32 bits; branch_taken = Branch_in AND (A - B == 0).
REQ-017 Not stalled: every output register loads its computed value at each edge; latency 1 cycle.
REQ-018 Mult/div unit: FSM states IDLE and BUSY; 6-bit counter; 32-bit HI and LO registers.
REQ-019 IDLE + mult/div in EX: capture operands (signed ops use magnitudes and record result sign) at the edge, counter=32, go BUSY, register-file writeback suppressed (RegWrite_out=0).
REQ-020 BUSY: one shift-add (mult) or restoring-subtract (div) step per edge, counter decrements; on the step taking counter 1->0, write sign-corrected HI/LO and return to IDLE at that same edge.
REQ-021 Result mapping: mult gives HI:LO = 64-bit product; div gives LO = quotient, HI = remainder (remainder takes dividend sign, quotient truncates toward zero).
REQ-022 Divide by zero: LO=0xFFFFFFFF, HI=dividend, completes at the first BUSY edge.
REQ-023 md_stall = BUSY AND instruction in EX is mfhi/mflo/mult/multu/div/divu; unrelated instructions proceed while BUSY.
REQ-024 md_stall high: output register loads a bubble (all control outputs 0, data outputs 0); the stalled instruction is re-evaluated next cycle.
REQ-025 mfhi/mflo in IDLE read current HI/LO; a new mult/div in EX at the completion edge of a previous one stalls that cycle and issues the next cycle.

Reset
REQ-026 rst at an edge: all outputs 0, HI=LO=0, counter=0, state IDLE; in-flight mult/div aborted; md_stall low the following cycle.
REQ-027 rst overrides issue, step and stall in the same cycle.

Verification
REQ-028 add, A=0x7FFFFFFF, B=1, ForwardA=00 -> one cycle later alu_result_out=0x80000000, RegWrite_out=1.
REQ-029 ForwardA=10, ex_mem_fwd=5, ForwardB=01, mem_wb_fwd=3, sub -> alu_result_out=2.
REQ-030 beq, equal operands, imm=0xFFFFFFFF, PC_plus4=0x100 -> branch_taken_out=1, branch_target_out=0xFC.
REQ-031 mult, A=-3, B=7, then mflo -> md_stall high 32 cycles, then alu_result_out=0xFFFFFFEB; mfhi -> 0xFFFFFFFF.
REQ-032 divu, A=100, B=0 -> next cycle HI=100, LO=0xFFFFFFFF; div, A=-7, B=2 -> LO=-3, HI=-1.
REQ-033 rst asserted 10 cycles into a div -> state IDLE, HI=LO=0, md_stall low the following cycle.
